// File: rtl/presorter_pkg.sv
// Shared constants, element type and layer-index helpers for the bitonic presorter.
// Defaults match the standard 512-bit beat / 32-bit element / 8-element chunk build.
package presorter_pkg;

  function automatic int unsigned layer_count(input int unsigned steps);
    return (steps == 0) ? 1 : steps * (steps + 1) / 2;
  endfunction

  // Flat layer index -> bitonic step (1-based); step s owns s consecutive layers.
  function automatic int unsigned layer_step(input int unsigned layer);
    int unsigned acc;
    int unsigned res;
    acc = 0;
    res = 1;
    for (int unsigned s = 1; s <= 32; s++) begin
      if (layer >= acc && layer < acc + s) res = s;
      acc += s;
    end
    return res;
  endfunction

  // Flat layer index -> sub-stage within its step (0 = reversed-half compare).
  function automatic int unsigned layer_sub(input int unsigned layer);
    int unsigned acc;
    int unsigned res;
    acc = 0;
    res = 0;
    for (int unsigned s = 1; s <= 32; s++) begin
      if (layer >= acc && layer < acc + s) res = layer - acc;
      acc += s;
    end
    return res;
  endfunction

  localparam int unsigned LP_AXI_DATA_WIDTH    = 512;
  localparam int unsigned LP_DATA_WIDTH        = 32;
  localparam int unsigned LP_KEY_WIDTH         = 32;
  localparam int unsigned LP_INIT_SORTED_CHUNK = 8;
  localparam int unsigned LP_ELEMS             = LP_AXI_DATA_WIDTH / LP_DATA_WIDTH;
  localparam int unsigned LP_CHUNK_NUM         = LP_ELEMS / LP_INIT_SORTED_CHUNK;
  localparam int unsigned LP_STEPS             = $clog2(LP_INIT_SORTED_CHUNK);
  localparam int unsigned LP_LAYERS            = layer_count(LP_STEPS);

  typedef logic [LP_DATA_WIDTH-1:0] elem_t;

endpackage

// File: rtl/presorter_stream_layer.sv
// One registered compare-and-swap layer of the bitonic network, applied to every chunk.
// STEP = 0 degenerates to a plain register stage.
module presort_layer
  import presorter_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = LP_AXI_DATA_WIDTH,
  parameter int unsigned DATA_WIDTH     = LP_DATA_WIDTH,
  parameter int unsigned KEY_WIDTH      = LP_KEY_WIDTH,
  parameter int unsigned STEP           = 1,
  parameter int unsigned SUB            = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      adv,
  input  logic                      in_valid,
  input  logic [AXI_DATA_WIDTH-1:0] in_data,
  input  logic                      in_last,
  input  logic                      in_desc,
  output logic                      out_valid,
  output logic [AXI_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      out_desc
);

  localparam int ELEMS = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int BLOCK = (STEP == 0) ? 1 : (1 << STEP);
  localparam int DIST  = (SUB == 0 || STEP <= SUB + 1) ? 1 : (1 << (STEP - 1 - SUB));

  logic [AXI_DATA_WIDTH-1:0] nxt;
  logic [KEY_WIDTH-1:0]      key_own, key_par;
  logic                      is_lo, swap;
  int                        j, partner;

  // Both members of a pair evaluate the same lo/hi decision, so the swap is consistent.
  always_comb begin
    nxt     = in_data;
    j       = 0;
    partner = 0;
    is_lo   = 1'b0;
    swap    = 1'b0;
    key_own = '0;
    key_par = '0;
    for (int i = 0; i < ELEMS; i++) begin
      if (SUB == 0) begin
        j       = i % BLOCK;
        partner = i - j + BLOCK - 1 - j;
        is_lo   = (j < BLOCK / 2);
      end else begin
        partner = i ^ DIST;
        is_lo   = ((i & DIST) == 0);
      end
      key_own = in_data[i*DATA_WIDTH +: KEY_WIDTH];
      key_par = in_data[partner*DATA_WIDTH +: KEY_WIDTH];
      if (is_lo) swap = in_desc ? (key_own < key_par) : (key_own > key_par);
      else       swap = in_desc ? (key_par < key_own) : (key_par > key_own);
      if (swap && STEP != 0) begin
        nxt[i*DATA_WIDTH +: DATA_WIDTH] = in_data[partner*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_desc  <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_data  <= nxt;
      out_last  <= in_last;
      out_desc  <= in_desc;
    end
  end

endmodule

// File: rtl/presorter_stream.sv
// Flow-controlled bitonic chunk presorter: a lock-step chain of registered CAS layers.
// Optional perf counters enabled by defining PRESORTER_PERF_CNT_EN.
module presorter_stream
  import presorter_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH    = LP_AXI_DATA_WIDTH,
  parameter int unsigned DATA_WIDTH        = LP_DATA_WIDTH,
  parameter int unsigned KEY_WIDTH         = LP_KEY_WIDTH,
  parameter int unsigned INIT_SORTED_CHUNK = LP_INIT_SORTED_CHUNK
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AXI_DATA_WIDTH-1:0] in_data,
  input  logic                      in_last,
  input  logic                      in_desc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [AXI_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      out_desc
`ifdef PRESORTER_PERF_CNT_EN
  ,
  output logic [31:0]               perf_beats,
  output logic [31:0]               perf_stalls
`endif
);

  localparam int unsigned STEPS  = $clog2(INIT_SORTED_CHUNK);
  localparam int unsigned LAYERS = layer_count(STEPS);

  logic                      adv;
  logic [LAYERS:0]           stg_valid, stg_last, stg_desc;
  logic [AXI_DATA_WIDTH-1:0] stg_data [LAYERS+1];

  // No bubble collapsing: the whole chain moves or holds together.
  assign adv      = !stg_valid[LAYERS] || out_ready;
  assign in_ready = adv;

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = in_data;
  assign stg_last[0]  = in_last;
  assign stg_desc[0]  = in_desc;

  for (genvar g = 0; g < LAYERS; g++) begin : g_layer
    presort_layer #(
      .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .KEY_WIDTH      (KEY_WIDTH),
      .STEP           ((STEPS == 0) ? 0 : layer_step(g)),
      .SUB            ((STEPS == 0) ? 0 : layer_sub(g))
    ) u_layer (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .adv       (adv),
      .in_valid  (stg_valid[g]),
      .in_data   (stg_data[g]),
      .in_last   (stg_last[g]),
      .in_desc   (stg_desc[g]),
      .out_valid (stg_valid[g+1]),
      .out_data  (stg_data[g+1]),
      .out_last  (stg_last[g+1]),
      .out_desc  (stg_desc[g+1])
    );
  end

  assign out_valid = stg_valid[LAYERS];
  assign out_data  = stg_data[LAYERS];
  assign out_last  = stg_last[LAYERS];
  assign out_desc  = stg_desc[LAYERS];

`ifdef PRESORTER_PERF_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (out_valid && out_ready)  perf_beats  <= perf_beats + 32'd1;
      if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
